// File: rtl/icache_dm_pkg.sv
// rtl/icache_dm_pkg.sv - shared types and constants for the direct-mapped instruction cache
// Purpose: cache FSM state encoding, NOP instruction and default line count.
// Ports: none (package).
package my_pkg;

    typedef enum logic {
        IC_FLUSH = 1'b0,
        IC_READY = 1'b1
    } ICACHE_State_Enum;

    localparam logic [31:0] NOP_INSTR        = 32'h00000013;
    localparam int          ICACHE_LINES_DEF = 16;

endpackage

// File: rtl/icache_dm_if.sv
// rtl/icache_dm_if.sv - fetch-side bus between the fetch FSM and the instruction cache
// Purpose: bundles lookup, refill, flush and status signals.
// Ports (master = fetch FSM side):
//   PC, MEM_DATA, ICACHE_WEn, FLUSH      : master -> cache
//   INSTR, match, PC_changed, FLUSH_BUSY : cache -> master
interface icache_dm_if;

    logic [31:0] PC;
    logic [31:0] MEM_DATA;
    logic        ICACHE_WEn;
    logic        FLUSH;
    logic [31:0] INSTR;
    logic        match;
    logic        PC_changed;
    logic        FLUSH_BUSY;

    modport master (
        output PC, MEM_DATA, ICACHE_WEn, FLUSH,
        input  INSTR, match, PC_changed, FLUSH_BUSY
    );

    modport slave (
        input  PC, MEM_DATA, ICACHE_WEn, FLUSH,
        output INSTR, match, PC_changed, FLUSH_BUSY
    );

endinterface

// File: rtl/icache_dm_line_ram.sv
// rtl/icache_dm_line_ram.sv - tag/valid/data storage for the direct-mapped instruction cache
// Purpose: unreset line array, one combinational read port, one synchronous write port
//          and a separate valid-clear port used by the invalidate sweep.
// Ports:
//   clk                : write clock
//   we, widx, wtag, wdata : refill write (sets valid)
//   clr, cidx          : clear valid of line cidx
//   ridx -> rvalid, rtag, rdata : combinational read
module icache_line_ram #(
    parameter int LINES = 16,
    parameter int IDX_W = $clog2(LINES),
    parameter int TAG_W = 30 - IDX_W
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] widx,
    input  logic [TAG_W-1:0] wtag,
    input  logic [31:0]      wdata,
    input  logic             clr,
    input  logic [IDX_W-1:0] cidx,
    input  logic [IDX_W-1:0] ridx,
    output logic             rvalid,
    output logic [TAG_W-1:0] rtag,
    output logic [31:0]      rdata
);

    logic             valid_arr [LINES];
    logic [TAG_W-1:0] tag_arr   [LINES];
    logic [31:0]      data_arr  [LINES];

    // No reset: contents are only trusted after the sweep has cleared every valid bit.
    // Clear and write never coincide (sweep vs. ready state); clear still wins for safety.
    always_ff @(posedge clk) begin
        if (clr) begin
            valid_arr[cidx] <= 1'b0;
        end else if (we) begin
            valid_arr[widx] <= 1'b1;
        end
        if (we) begin
            tag_arr[widx]  <= wtag;
            data_arr[widx] <= wdata;
        end
    end

    assign rvalid = valid_arr[ridx];
    assign rtag   = tag_arr[ridx];
    assign rdata  = data_arr[ridx];

endmodule

// File: rtl/icache_dm.sv
// rtl/icache_dm.sv - direct-mapped single-word-line instruction cache with invalidate sweep
// Purpose: combinational lookup, refill on active-low strobe, PC change detect,
//          post-reset / on-request invalidate sweep.
// Ports:
//   clk  : clock
//   rstn : asynchronous active-low reset
//   bus  : icache_dm_if.slave (PC, MEM_DATA, ICACHE_WEn, FLUSH in;
//          INSTR, match, PC_changed, FLUSH_BUSY out)
module icache_dm
    import my_pkg::*;
#(
    parameter int LINES = ICACHE_LINES_DEF,
    parameter int IDX_W = $clog2(LINES)
) (
    input  logic        clk,
    input  logic        rstn,
    icache_dm_if.slave  bus
);

    localparam int TAG_W = 30 - IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINES - 1);

    ICACHE_State_Enum state;
    logic [IDX_W-1:0] flush_idx;
    logic [31:0]      pc_q;

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic             rvalid;
    logic [TAG_W-1:0] rtag;
    logic [31:0]      rdata;
    logic             ram_we;
    logic             ram_clr;
    logic             hit;
    logic             unused_pc_bits;

    assign idx            = bus.PC[IDX_W+1:2];
    assign tag            = bus.PC[31:IDX_W+2];
    assign unused_pc_bits = ^bus.PC[1:0];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IC_FLUSH;
            flush_idx <= '0;
            pc_q      <= '0;
        end else begin
            pc_q <= bus.PC;
            if (bus.FLUSH) begin
                // Restart the sweep from line 0 whatever state we are in.
                state     <= IC_FLUSH;
                flush_idx <= '0;
            end else begin
                case (state)
                    IC_FLUSH: begin
                        flush_idx <= flush_idx + 1'b1;
                        if (flush_idx == LAST_IDX) begin
                            state <= IC_READY;
                        end
                    end
                    default: state <= IC_READY;
                endcase
            end
        end
    end

    assign ram_clr = (state == IC_FLUSH);
    assign ram_we  = (state == IC_READY) && !bus.ICACHE_WEn && !bus.FLUSH;

    icache_line_ram #(
        .LINES (LINES),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_ram (
        .clk    (clk),
        .we     (ram_we),
        .widx   (idx),
        .wtag   (tag),
        .wdata  (bus.MEM_DATA),
        .clr    (ram_clr),
        .cidx   (flush_idx),
        .ridx   (idx),
        .rvalid (rvalid),
        .rtag   (rtag),
        .rdata  (rdata)
    );

    // Array contents are meaningless during the sweep, so lookups are masked there.
    assign hit            = (state == IC_READY) && rvalid && (rtag == tag);
    assign bus.match      = hit;
    assign bus.INSTR      = hit ? rdata : NOP_INSTR;
    assign bus.PC_changed = (bus.PC[31:2] != pc_q[31:2]);
    assign bus.FLUSH_BUSY = (state == IC_FLUSH);

endmodule

// File: tb/tb_icache_dm.sv
// tb/tb_icache_dm.sv - self-checking bench for icache_dm
module tb_icache_dm;
    import my_pkg::*;

    localparam int LINES = 16;
    localparam int IDX_W = $clog2(LINES);

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    icache_dm_if bus();

    icache_dm #(.LINES(LINES)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: each line remembers the full word address it holds.
    int          m_busy;
    logic        m_valid [LINES];
    logic [29:0] m_addr  [LINES];
    logic [31:0] m_data  [LINES];
    logic [31:0] m_pcq;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] md;
        logic        wen;
        logic        e_match;
        logic [31:0] e_instr;
        logic        e_chg;
    } vec_t;

    vec_t tbl [14];

    function automatic void model_reset();
        m_busy = LINES;
        for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
        m_pcq = 32'h0;
    endfunction

    function automatic void model_edge();
        int i;
        if (!rstn) begin
            model_reset();
            return;
        end
        i = int'(bus.PC[31:2] % LINES);
        if (bus.FLUSH) begin
            m_busy = LINES;
            for (int k = 0; k < LINES; k++) m_valid[k] = 1'b0;
        end else if (m_busy > 0) begin
            m_busy = m_busy - 1;
        end else if (!bus.ICACHE_WEn) begin
            m_valid[i] = 1'b1;
            m_addr[i]  = bus.PC[31:2];
            m_data[i]  = bus.MEM_DATA;
        end
        m_pcq = bus.PC;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] md, input logic wen, input logic fl);
        bus.PC         = pc;
        bus.MEM_DATA   = md;
        bus.ICACHE_WEn = wen;
        bus.FLUSH      = fl;
        #1;
    endtask

    task automatic chk_model(input string name);
        int          i;
        logic        e_busy;
        logic        e_match;
        i       = int'(bus.PC[31:2] % LINES);
        e_busy  = (m_busy > 0);
        e_match = !e_busy && m_valid[i] && (m_addr[i] == bus.PC[31:2]);
        chk({name, ".busy"},  bus.FLUSH_BUSY, e_busy);
        chk({name, ".match"}, bus.match, e_match);
        chk({name, ".instr"}, bus.INSTR, e_match ? m_data[i] : NOP_INSTR);
        chk({name, ".pcchg"}, bus.PC_changed, bus.PC[31:2] != m_pcq[31:2]);
    endtask

    task automatic chk_sweep(input string name);
        for (int c = 0; c < LINES; c++) begin
            chk({name, ".busy"},  bus.FLUSH_BUSY, 1'b1);
            chk({name, ".match"}, bus.match, 1'b0);
            chk({name, ".instr"}, bus.INSTR, NOP_INSTR);
            tick();
        end
        chk({name, ".done"}, bus.FLUSH_BUSY, 1'b0);
    endtask

    initial begin
        tbl[0]  = '{32'h40,  32'hDEADBEEF, 1'b0, 1'b0, NOP_INSTR,    1'b1};
        tbl[1]  = '{32'h40,  32'h0,        1'b1, 1'b1, 32'hDEADBEEF, 1'b0};
        tbl[2]  = '{32'h80,  32'h0,        1'b1, 1'b0, NOP_INSTR,    1'b1};
        tbl[3]  = '{32'h04,  32'h11,       1'b0, 1'b0, NOP_INSTR,    1'b1};
        tbl[4]  = '{32'h44,  32'h22,       1'b0, 1'b0, NOP_INSTR,    1'b1};
        tbl[5]  = '{32'h44,  32'h0,        1'b1, 1'b1, 32'h22,       1'b0};
        tbl[6]  = '{32'h04,  32'h0,        1'b1, 1'b0, NOP_INSTR,    1'b1};
        tbl[7]  = '{32'h100, 32'h0,        1'b1, 1'b0, NOP_INSTR,    1'b1};
        tbl[8]  = '{32'h100, 32'h0,        1'b1, 1'b0, NOP_INSTR,    1'b0};
        tbl[9]  = '{32'h100, 32'h0,        1'b1, 1'b0, NOP_INSTR,    1'b0};
        tbl[10] = '{32'h104, 32'h0,        1'b1, 1'b0, NOP_INSTR,    1'b1};
        tbl[11] = '{32'h100, 32'h0,        1'b1, 1'b0, NOP_INSTR,    1'b1};
        tbl[12] = '{32'h101, 32'h0,        1'b1, 1'b0, NOP_INSTR,    1'b0};
        tbl[13] = '{32'h40,  32'h0,        1'b1, 1'b1, 32'hDEADBEEF, 1'b1};

        // Reset state
        model_reset();
        drive(32'h10, 32'h0, 1'b1, 1'b0);
        tick();
        tick();
        chk("rst.busy",  bus.FLUSH_BUSY, 1'b1);
        chk("rst.match", bus.match, 1'b0);
        chk("rst.instr", bus.INSTR, NOP_INSTR);
        chk("rst.pcchg_nz", bus.PC_changed, 1'b1);
        drive(32'h0, 32'h0, 1'b1, 1'b0);
        chk("rst.pcchg_z", bus.PC_changed, 1'b0);

        // Sweep after reset release
        rstn = 1'b1;
        #1;
        chk_sweep("sweep0");

        // Lookup / refill / conflict / PC tracking vectors
        for (int v = 0; v < 14; v++) begin
            drive(tbl[v].pc, tbl[v].md, tbl[v].wen, 1'b0);
            chk($sformatf("vec%0d.match", v), bus.match, tbl[v].e_match);
            chk($sformatf("vec%0d.instr", v), bus.INSTR, tbl[v].e_instr);
            chk($sformatf("vec%0d.pcchg", v), bus.PC_changed, tbl[v].e_chg);
            chk($sformatf("vec%0d.busy", v),  bus.FLUSH_BUSY, 1'b0);
            tick();
        end

        // FLUSH beats refill, then writes ignored during the sweep
        drive(32'h08, 32'h55, 1'b0, 1'b1);
        chk("flush.busy_pre", bus.FLUSH_BUSY, 1'b0);
        tick();
        drive(32'h08, 32'h55, 1'b0, 1'b0);
        chk_sweep("sweep1");
        drive(32'h08, 32'h0, 1'b1, 1'b0);
        chk("flush.drop_match", bus.match, 1'b0);
        chk("flush.drop_instr", bus.INSTR, NOP_INSTR);
        drive(32'h40, 32'h0, 1'b1, 1'b0);
        chk("flush.cleared", bus.match, 1'b0);
        tick();

        // Reset at sweep cycle 7
        drive(32'h0C, 32'h77, 1'b1, 1'b1);
        tick();
        drive(32'h0C, 32'h77, 1'b0, 1'b0);
        for (int c = 0; c < 7; c++) tick();
        chk("midrst.busy_pre", bus.FLUSH_BUSY, 1'b1);
        rstn = 1'b0;
        model_reset();
        #1;
        chk("midrst.busy", bus.FLUSH_BUSY, 1'b1);
        chk("midrst.instr", bus.INSTR, NOP_INSTR);
        tick();
        rstn = 1'b1;
        #1;
        chk_sweep("sweep2");
        drive(32'h0C, 32'h0, 1'b1, 1'b0);
        chk("midrst.no_write", bus.match, 1'b0);
        tick();

        // Randomized traffic against the reference model
        for (int n = 0; n < 600; n++) begin
            logic [31:0] pc;
            if ($urandom_range(0, 3) == 0) begin
                pc = bus.PC;
            end else begin
                pc = ($urandom_range(0, 3) << (IDX_W + 2))
                   | ($urandom_range(0, LINES - 1) << 2)
                   | $urandom_range(0, 3);
            end
            drive(pc, $urandom, ($urandom_range(0, 2) != 0), ($urandom_range(0, 59) == 0));
            chk_model($sformatf("rnd%0d", n));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/icache_dm.md
# icache_dm

Direct-mapped, single-word-line instruction cache that sits between the PC/fetch stage and the instruction-memory control FSM. It serves instructions on a hit and raises `match`. It produces the `PC_changed` indication that the fetch FSM consumes. It accepts refill writes from instruction memory when the FSM drives `ICACHE_WEn` low. Its tag/valid/data array has no reset, so the block runs an invalidate sweep after reset and on request.

## Interface
Parameters:
- `LINES`, 16: number of cache lines; power of two, at least 2.
- `IDX_W`, $clog2(LINES): index width, derived; do not override.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rstn`, in, 1: asynchronous, active-low reset.
- `PC`, in, 32: fetch address; word aligned, `PC[1:0]` ignored.
- `MEM_DATA`, in, 32: refill word from instruction memory.
- `ICACHE_WEn`, in, 1: active-low refill write strobe from the fetch FSM.
- `FLUSH`, in, 1: invalidate request, sampled on the clock edge.
- `INSTR`, out, 32: cached instruction on a hit, otherwise NOP `32'h00000013`.
- `match`, out, 1: hit indication.
- `PC_changed`, out, 1: high when `PC` differs from its value one cycle earlier.
- `FLUSH_BUSY`, out, 1: high while an invalidate sweep is in progress.

## Operation
Address split:
- index = `PC[IDX_W+1:2]`
- tag = `PC[31:IDX_W+2]`, width `30-IDX_W`

States:
- `IC_FLUSH`: invalidate sweep. Entered on reset, and on `FLUSH=1` from either state.
- `IC_READY`: normal lookup and refill.

Flush sweep:
- Counter `flush_idx` (IDX_W bits) is reset to 0 on entry.
- Each cycle in `IC_FLUSH`, line `flush_idx` gets valid=0, then the counter increments.
- After clearing line `LINES-1`, the block moves to `IC_READY`.
- `FLUSH=1` during a sweep restarts it at index 0.

Lookup (combinational, `IC_READY` only):
- `match = valid[idx] && tag_arr[idx]==tag`.
- `INSTR` = `data[idx]` if `match`, else NOP.
- In `IC_FLUSH`: `match=0` and `INSTR`=NOP regardless of array contents.

Refill:
- Condition: rising edge with `ICACHE_WEn=0`, state `IC_READY`, and `FLUSH=0`.
- Action: `data[idx]<=MEM_DATA`, `tag_arr[idx]<=tag`, `valid[idx]<=1`, using the `PC` present at that edge.
- A refill unconditionally replaces any conflicting line.

PC tracking:
- `pc_q <= PC` every cycle; reset value 0.
- `PC_changed = (PC[31:2] != pc_q[31:2])`, combinational.

Priorities and boundary cases:
- `FLUSH` beats refill; the write is dropped.
- Writes are ignored in `IC_FLUSH`.
- Reset mid-sweep or mid-operation returns to `IC_FLUSH` with `flush_idx=0`.
- Array contents are undefined after reset and are never observed until rewritten, because the sweep covers every line.

Reset values:
- state `IC_FLUSH`, `flush_idx=0`, `pc_q=0`
- `FLUSH_BUSY=1`, `match=0`, `INSTR=NOP`
- `PC_changed = (PC!=0)`

## Timing
- Sweep length: `FLUSH_BUSY` is high for exactly `LINES` cycles after reset release or the last `FLUSH` edge. `IC_READY` begins on the following edge.
- Hit latency: 0 cycles (combinational from `PC`).
- Refill-to-hit: a write at edge N makes `match=1` for the same `PC` from just after edge N.
- `PC_changed` is a combinational level, high for the cycle in which the new `PC` is first presented. The fetch FSM samples it at the next edge.
- Every output driven from an array read settles within one cycle of `PC`. There is no multicycle path.

## Structure
- `my_pkg` gets:
  - enum `ICACHE_State_Enum {IC_FLUSH, IC_READY}`
  - constant `NOP_INSTR = 32'h00000013`
  - constant `ICACHE_LINES_DEF = 16`
- One sub-module, `icache_line_ram`: tag+valid+data array with one combinational read port and one synchronous write port. It has no reset, and a separate valid-clear port drives the sweep.
- `icache_dm` holds the FSM, `flush_idx`, `pc_q`, compare logic and output muxing.

## Test plan
- Reset → for cycles 0–15: `FLUSH_BUSY=1`, `match=0`, `INSTR=32'h00000013`. Cycle 16: `FLUSH_BUSY=0`.
- Post-sweep: `PC=0x40`, `MEM_DATA=0xDEADBEEF`, `ICACHE_WEn=0` for 1 cycle → next cycle `match=1`, `INSTR=0xDEADBEEF`. `PC=0x80` (different tag) → `match=0`, `INSTR`=NOP.
- Conflict: refill `PC=0x04` with 0x11, then `PC=0x44` with 0x22 → `PC=0x44` hits with 0x22; `PC=0x04` misses.
- `PC` held at 0x100 for 3 cycles, then 0x104 → `PC_changed=0` for the held cycles, 1 in the cycle 0x104 appears. `PC=0x101` → `PC_changed` stays 0.
- `FLUSH=1` together with `ICACHE_WEn=0` at `PC=0x08` → write dropped; 16 busy cycles follow; then `PC=0x08` gives `match=0`.
- `rstn` pulsed low at sweep cycle 7 → `FLUSH_BUSY` high for a full 16 cycles after release; no early `IC_READY`.
